// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialization sequencer: owns the DIMM command/address bus
// from init_start until init_done, walking the JEDEC mode-register sequence.
module ddr2_init_seq #(
    parameter int unsigned BA_WIDTH    = 3,
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned T_INIT      = 100,
    parameter int unsigned T_XPR       = 20,
    parameter int unsigned T_RP        = 4,
    parameter int unsigned T_MRD       = 2,
    parameter int unsigned T_RFC       = 26,
    parameter int unsigned T_DLLK      = 200,
    parameter int unsigned CAS_LATENCY = 5,
    parameter int unsigned WR          = 6,
    parameter int unsigned DQS_N_DIS   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  cke,
    output logic                  cs_n,
    output logic                  ras_n,
    output logic                  cas_n,
    output logic                  we_n,
    output logic [BA_WIDTH-1:0]   ba,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  odt
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_MAX = max2(max2(max2(T_INIT, T_XPR), max2(T_RP, T_MRD)), T_RFC);
    localparam int unsigned CW    = $clog2(T_MAX) + 1;
    localparam int unsigned DW    = $clog2(T_DLLK) + 1;

    localparam logic [ADDR_WIDTH-1:0] MR_VAL    =
        ADDR_WIDTH'((((WR - 1) % 8) << 9) | ((CAS_LATENCY % 8) << 4) | 2);
    localparam logic [ADDR_WIDTH-1:0] MR_DLL    = MR_VAL | ADDR_WIDTH'(32'h100);
    localparam logic [ADDR_WIDTH-1:0] EMR1_BASE = ADDR_WIDTH'((DQS_N_DIS % 2) << 10);
    localparam logic [ADDR_WIDTH-1:0] EMR1_OCD  = EMR1_BASE | ADDR_WIDTH'(32'h380);
    localparam logic [ADDR_WIDTH-1:0] PREA_ADDR = ADDR_WIDTH'(32'h400);

    typedef enum logic [3:0] {
        IDLE, CKE_LOW, CKE_HIGH, PREA1, EMRS2, EMRS3, EMRS1, MRS_DLLRST,
        PREA2, REF1, REF2, MRS, EMRS1_OCD, EMRS1_EXIT, WAIT_DLL, DONE
    } state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [DW-1:0]           dll_cnt, dll_d;
    logic                    first, dll_ok;
    logic                    cke_d, cs_n_d, ras_n_d, cas_n_d, we_n_d, busy_d, done_d;
    logic [BA_WIDTH-1:0]     ba_d;
    logic [ADDR_WIDTH-1:0]   addr_d;

    // Residency of each state minus one (command cycle plus its gap)
    function automatic logic [CW-1:0] dur_m1(input state_t s);
        case (s)
            CKE_LOW:                       dur_m1 = CW'(T_INIT - 1);
            CKE_HIGH:                      dur_m1 = CW'(T_XPR - 1);
            PREA1, PREA2:                  dur_m1 = CW'(T_RP - 1);
            EMRS2, EMRS3, EMRS1, MRS_DLLRST,
            MRS, EMRS1_OCD, EMRS1_EXIT:    dur_m1 = CW'(T_MRD - 1);
            REF1, REF2:                    dur_m1 = CW'(T_RFC - 1);
            default:                       dur_m1 = '0;
        endcase
    endfunction

    // Fixed successor order of the init sequence
    function automatic state_t succ(input state_t s, input logic dll_rdy);
        case (s)
            CKE_LOW:    succ = CKE_HIGH;
            CKE_HIGH:   succ = PREA1;
            PREA1:      succ = EMRS2;
            EMRS2:      succ = EMRS3;
            EMRS3:      succ = EMRS1;
            EMRS1:      succ = MRS_DLLRST;
            MRS_DLLRST: succ = PREA2;
            PREA2:      succ = REF1;
            REF1:       succ = REF2;
            REF2:       succ = MRS;
            MRS:        succ = EMRS1_OCD;
            EMRS1_OCD:  succ = EMRS1_EXIT;
            EMRS1_EXIT: succ = dll_rdy ? DONE : WAIT_DLL;
            default:    succ = IDLE;
        endcase
    endfunction

    // Command issues only in the first cycle of a state; the rest is the gap
    assign first  = (cnt == dur_m1(state));
    // Next cycle reaches T_DLLK cycles since the DLL-reset MRS
    assign dll_ok = (dll_cnt >= DW'(T_DLLK - 1));

    // State, wait counter and saturating DLL counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dll_cnt <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            dll_cnt <= dll_d;
        end
    end

    // Next state, counters and bus decode of the current state
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        dll_d   = dll_cnt;
        cke_d   = 1'b0;
        cs_n_d  = 1'b1;
        ras_n_d = 1'b1;
        cas_n_d = 1'b1;
        we_n_d  = 1'b1;
        ba_d    = '0;
        addr_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (state == MRS_DLLRST && first) begin
            dll_d = DW'(1);
        end else if (dll_cnt != '0 && dll_cnt < DW'(T_DLLK)) begin
            dll_d = dll_cnt + DW'(1);
        end

        case (state)
            IDLE, DONE: begin
                if (init_start) begin
                    state_d = CKE_LOW;
                    cnt_d   = dur_m1(CKE_LOW);
                    dll_d   = '0;
                end
            end
            WAIT_DLL: begin
                if (dll_ok) state_d = DONE;
            end
            default: begin
                if (cnt == '0) begin
                    state_d = succ(state, dll_ok);
                    cnt_d   = dur_m1(succ(state, dll_ok));
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
        endcase

        case (state)
            IDLE: begin
            end
            CKE_LOW: begin
                busy_d = 1'b1;
            end
            DONE: begin
                cke_d  = 1'b1;
                cs_n_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b1;
                cke_d  = 1'b1;
                cs_n_d = 1'b0;
                if (first) begin
                    case (state)
                        PREA1, PREA2: begin
                            ras_n_d = 1'b0;
                            we_n_d  = 1'b0;
                            addr_d  = PREA_ADDR;
                        end
                        REF1, REF2: begin
                            ras_n_d = 1'b0;
                            cas_n_d = 1'b0;
                        end
                        EMRS2, EMRS3, EMRS1, MRS_DLLRST, MRS, EMRS1_OCD, EMRS1_EXIT: begin
                            ras_n_d = 1'b0;
                            cas_n_d = 1'b0;
                            we_n_d  = 1'b0;
                            case (state)
                                EMRS2:      ba_d = BA_WIDTH'(2);
                                EMRS3:      ba_d = BA_WIDTH'(3);
                                EMRS1, EMRS1_EXIT: begin
                                    ba_d   = BA_WIDTH'(1);
                                    addr_d = EMR1_BASE;
                                end
                                EMRS1_OCD: begin
                                    ba_d   = BA_WIDTH'(1);
                                    addr_d = EMR1_OCD;
                                end
                                MRS_DLLRST: addr_d = MR_DLL;
                                default:    addr_d = MR_VAL;
                            endcase
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    // Registered bus and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cke       <= 1'b0;
            cs_n      <= 1'b1;
            ras_n     <= 1'b1;
            cas_n     <= 1'b1;
            we_n      <= 1'b1;
            ba        <= '0;
            addr      <= '0;
            odt       <= 1'b0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
        end else begin
            cke       <= cke_d;
            cs_n      <= cs_n_d;
            ras_n     <= ras_n_d;
            cas_n     <= cas_n_d;
            we_n      <= we_n_d;
            ba        <= ba_d;
            addr      <= addr_d;
            odt       <= 1'b0;
            init_busy <= busy_d;
            init_done <= done_d;
        end
    end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Scoreboard bench for ddr2_init_seq: three instances (defaults, T_DLLK=10,
// DQS_N_DIS=1) share stimulus; expected commands/probes are queued up front.
module tb_ddr2_init_seq;

    typedef struct {
        int unsigned tick;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [13:0] addr;
        bit          chk_addr;
        bit          is_done;
    } ev_t;

    typedef struct {
        int unsigned tick;
        int          kind;    // 0: output snapshot, 1: run totals, 2: queues drained
        logic [24:0] snap;
        int unsigned cnt;
    } probe_t;

    // {cke, cs_n, ras_n, cas_n, we_n, ba[2:0], addr[13:0], odt, busy, done}
    localparam logic [24:0] RST_SNAP  = {1'b0, 4'b1111, 3'd0, 14'd0, 1'b0, 1'b0, 1'b0};
    localparam logic [24:0] DONE_SNAP = {1'b1, 4'b0111, 3'd0, 14'd0, 1'b0, 1'b0, 1'b1};
    localparam logic [24:0] LOW_SNAP  = {1'b0, 4'b1111, 3'd0, 14'd0, 1'b0, 1'b1, 1'b0};

    logic             clk = 1'b0;
    logic             rst;
    logic             init_start;
    logic [2:0][24:0] snap_w;
    int unsigned      tick = 0;
    int               n_tests = 0;
    int               n_fail = 0;

    ev_t    q0[$], q1[$], q2[$];
    probe_t pq[$];

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned DLLK = (g == 1) ? 10 : 200;
        localparam int unsigned DQS  = (g == 2) ? 1 : 0;
        logic        init_busy, init_done, cke, cs_n, ras_n, cas_n, we_n, odt;
        logic [2:0]  ba;
        logic [13:0] addr;
        ddr2_init_seq #(.T_DLLK(DLLK), .DQS_N_DIS(DQS)) dut (
            .clk(clk), .rst(rst), .init_start(init_start),
            .init_busy(init_busy), .init_done(init_done),
            .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
            .ba(ba), .addr(addr), .odt(odt)
        );
        assign snap_w[g] = {cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt, init_busy, init_done};
    end

    task automatic push_ev(input int d, input ev_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic push_probe(input int unsigned t, input int k, input logic [24:0] sn,
                              input int unsigned c);
        probe_t p;
        p.tick = t; p.kind = k; p.snap = sn; p.cnt = c;
        pq.push_back(p);
    endtask

    // Queue the first n commands of a run started at tick s (plus done if full)
    task automatic push_seq(input int unsigned s, input int n);
        int unsigned rel [11];
        logic [3:0]  cmd [11];
        logic [2:0]  bav [11];
        logic [13:0] av  [11];
        bit          emr [11];
        bit          ck  [11];
        logic [13:0] base;
        ev_t         e;
        rel = '{121, 125, 127, 129, 131, 133, 137, 163, 189, 191, 193};
        cmd = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
                4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        bav = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
        av  = '{14'h400, 14'h000, 14'h000, 14'h000, 14'hB52, 14'h400,
                14'h000, 14'h000, 14'hA52, 14'h380, 14'h000};
        emr = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};
        ck  = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
        for (int d = 0; d < 3; d++) begin
            base = (d == 2) ? 14'h400 : 14'h000;
            for (int i = 0; i < n; i++) begin
                e.tick     = s + rel[i];
                e.cmd      = cmd[i];
                e.ba       = bav[i];
                e.addr     = av[i] | (emr[i] ? base : 14'h000);
                e.chk_addr = ck[i];
                e.is_done  = 1'b0;
                push_ev(d, e);
            end
            if (n == 11) begin
                e.tick     = s + ((d == 1) ? 195 : 331);
                e.cmd      = 4'b0111;
                e.ba       = 3'd0;
                e.addr     = 14'h000;
                e.chk_addr = 1'b0;
                e.is_done  = 1'b1;
                push_ev(d, e);
            end
        end
    endtask

    task automatic wait_to(input int unsigned t);
        while (tick < t) @(negedge clk);
    endtask

    // Monitor state
    int unsigned cmd_cnt [3];
    int unsigned viol    [3];
    bit          prev_done [3];
    logic [24:0] ms;
    ev_t         oe, xe;
    bit          have, is_cmd, rise;
    probe_t      p;
    int          qsz;

    // Monitor: protocol tallies, scoreboard pops on commands/done, probe checks
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            ms     = snap_w[i];
            is_cmd = !ms[23] && (ms[22:20] != 3'b111);
            rise   = ms[0] && !prev_done[i];
            prev_done[i] = ms[0];
            if (ms[2]) viol[i]++;
            if (!ms[24] && !ms[23]) viol[i]++;
            if (is_cmd) begin
                cmd_cnt[i]++;
                if (ms[23:20] == 4'b0010 && !ms[13]) viol[i]++;
            end
            if (is_cmd || rise) begin
                oe.tick = tick; oe.cmd = ms[23:20]; oe.ba = ms[19:17];
                oe.addr = ms[16:3]; oe.is_done = rise; oe.chk_addr = 1'b1;
                have = 1'b0;
                case (i)
                    0: if (q0.size() != 0) begin xe = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() != 0) begin xe = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() != 0) begin xe = q2.pop_front(); have = 1'b1; end
                endcase
                n_tests++;
                if (!have) begin
                    n_fail++;
                    $display("FAIL unexpected_event dut%0d: got tick=%0d cmd=%b ba=%0d addr=%h done=%0d, required no event",
                             i, oe.tick, oe.cmd, oe.ba, oe.addr, oe.is_done);
                end else if (oe.tick != xe.tick || oe.is_done != xe.is_done ||
                             (!xe.is_done && (oe.cmd != xe.cmd || oe.ba != xe.ba ||
                              (xe.chk_addr && oe.addr != xe.addr)))) begin
                    n_fail++;
                    $display("FAIL event dut%0d: got tick=%0d cmd=%b ba=%0d addr=%h done=%0d, required tick=%0d cmd=%b ba=%0d addr=%h done=%0d",
                             i, oe.tick, oe.cmd, oe.ba, oe.addr, oe.is_done,
                             xe.tick, xe.cmd, xe.ba, xe.addr, xe.is_done);
                end
            end
        end

        while (pq.size() != 0 && pq[0].tick <= tick) begin
            p = pq.pop_front();
            if (p.tick != tick) begin
                n_tests++;
                n_fail++;
                $display("FAIL probe_missed: got tick=%0d, required tick=%0d", tick, p.tick);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    case (p.kind)
                        0: begin
                            n_tests++;
                            if (snap_w[i] != p.snap) begin
                                n_fail++;
                                $display("FAIL outputs dut%0d tick=%0d: got %b, required %b",
                                         i, tick, snap_w[i], p.snap);
                            end
                        end
                        1: begin
                            n_tests++;
                            if (cmd_cnt[i] != p.cnt) begin
                                n_fail++;
                                $display("FAIL cmd_count dut%0d: got %0d, required %0d",
                                         i, cmd_cnt[i], p.cnt);
                            end
                            n_tests++;
                            if (viol[i] != 0) begin
                                n_fail++;
                                $display("FAIL protocol dut%0d: got %0d violations, required 0",
                                         i, viol[i]);
                            end
                            cmd_cnt[i] = 0;
                            viol[i]    = 0;
                        end
                        default: begin
                            case (i)
                                0:       qsz = q0.size();
                                1:       qsz = q1.size();
                                default: qsz = q2.size();
                            endcase
                            n_tests++;
                            if (qsz != 0) begin
                                n_fail++;
                                $display("FAIL missing_events dut%0d: got %0d pending, required 0",
                                         i, qsz);
                            end
                        end
                    endcase
                end
            end
        end
    end

    int unsigned s;
    int unsigned t;

    // Stimulus: reset, runs with ignored start, re-init, mid-run reset, replay
    initial begin
        rst        = 1'b1;
        init_start = 1'b0;
        repeat (3) @(negedge clk);
        push_probe(tick + 1, 0, RST_SNAP, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Run A: stray init_start at cycle 50 must be ignored
        s = tick + 1;
        push_seq(s, 11);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_to(s + 49);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_to(s + 340);
        push_probe(tick + 1, 1, '0, 11);
        @(negedge clk);

        // Run B: re-init from done; done holds at cycle 0, drops at cycle 1
        s = tick + 1;
        push_probe(s, 0, DONE_SNAP, 0);
        push_probe(s + 1, 0, LOW_SNAP, 0);
        push_seq(s, 11);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_to(s + 340);
        push_probe(tick + 1, 1, '0, 11);
        @(negedge clk);

        // Run C: reset at cycle 150 aborts after 7 commands
        s = tick + 1;
        push_seq(s, 7);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_to(s + 149);
        rst = 1'b1;
        push_probe(s + 150, 0, RST_SNAP, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_to(s + 180);
        push_probe(tick + 1, 1, '0, 7);
        @(negedge clk);

        // Reset and init_start together: reset wins, nothing starts
        push_probe(tick + 1, 0, RST_SNAP, 0);
        push_probe(tick + 2, 0, RST_SNAP, 0);
        rst        = 1'b1;
        init_start = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        init_start = 1'b0;
        t = tick;
        wait_to(t + 20);
        push_probe(tick + 1, 1, '0, 0);
        @(negedge clk);

        // Run D: full replay after abort
        s = tick + 1;
        push_seq(s, 11);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_to(s + 340);
        push_probe(tick + 1, 1, '0, 11);
        push_probe(tick + 2, 2, '0, 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
